// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin scheduler with registered one-hot grants
// Optional hold-limit revoke and expire pulse built only when ARB_HOLD_LIMIT_EN is defined.
module rr_grant_scheduler #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           res_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           expire
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [IDW-1:0] next_ptr;
  logic           owner_req;
  logic           revoke;
  logic [IDW-1:0] pick_start;
  logic [N-1:0]   pick_vec;
  logic [2*N-1:0] pick_dbl;
  logic [N-1:0]   pick_rot;
  logic [IDW-1:0] pick_off;
  logic [IDW:0]   pick_sum;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;

  assign next_ptr  = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
  assign owner_req = |(req & grant_q);

  // While busy the owner is masked out and the search starts just past it,
  // which serves both a release and a forced revoke with one picker.
  assign pick_start = (state_q == IDLE) ? ptr_q : next_ptr;
  assign pick_vec   = (state_q == IDLE) ? req : (req & ~grant_q);
  assign pick_dbl   = {pick_vec, pick_vec} >> pick_start;
  assign pick_rot   = pick_dbl[N-1:0];

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_rot[i[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_off   = i[IDW-1:0];
      end
    end
  end

  always_comb begin
    pick_sum = {1'b0, pick_start} + {1'b0, pick_off};
    if (pick_sum >= (IDW+1)'(N)) pick_sum = pick_sum - (IDW+1)'(N);
    pick_idx = pick_sum[IDW-1:0];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          valid_d = 1'b1;
          id_d    = pick_idx;
        end
      end
      BUSY: begin
        if (!owner_req || revoke) begin
          ptr_d = next_ptr;
          if (pick_found) begin
            grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
            valid_d = 1'b1;
            id_d    = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;
  logic       expire_q, expire_d;

  // A release always beats the limit because revoke requires the owner still requesting.
  assign revoke = (state_q == BUSY) && owner_req && pick_found && (hold_q == 8'(MAX_HOLD));

  always_comb begin
    hold_d   = hold_q;
    expire_d = 1'b0;
    if (state_q == IDLE) begin
      if (pick_found) hold_d = 8'd1;
    end else if (!owner_req) begin
      hold_d = pick_found ? 8'd1 : 8'd0;
    end else if (revoke) begin
      hold_d   = 8'd1;
      expire_d = 1'b1;
    end else if (hold_q != 8'(MAX_HOLD)) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hold_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign revoke          = 1'b0;
  assign expire          = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb/tb_rr_grant_scheduler.sv - randomized and directed bench for rr_grant_scheduler
// Reference model tracks owner/pointer/hold count as plain integers.
module tb_rr_grant_scheduler;

  localparam int N   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           res_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           expire;

  int n_cmp = 0;
  int n_err = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_exp   = 1'b0;

  rr_grant_scheduler #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .res_n(res_n), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .expire(expire)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [N-1:0] v, int start);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (start + i) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_exp = 1'b0;
  endtask

  task automatic model_edge();
    int k, nxt;
    logic [N-1:0] oth;
    if (!res_n) begin
      m_reset();
      return;
    end
    m_exp = 1'b0;
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
      if (m_owner >= 0) m_hold = 1;
    end else begin
      k = m_owner;
      nxt = (k + 1) % N;
      oth = req;
      oth[k] = 1'b0;
      if (!req[k]) begin
        m_ptr = nxt;
        m_owner = pick(oth, nxt);
        m_hold = 1;
      end else if (HL && m_hold == MH && oth != '0) begin
        m_ptr = nxt;
        m_owner = pick(oth, nxt);
        m_hold = 1;
        m_exp = 1'b1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  function automatic logic [N+IDW+1:0] exp_vec();
    logic [N-1:0] g;
    logic [IDW-1:0] id;
    g = '0;
    id = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      id = IDW'(m_owner);
    end
    return {g, (m_owner >= 0), id, m_exp};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    m_reset();
    req = '0;
    step();
    step();
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    m_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if ({grant, grant_valid, grant_id, expire} !== 8'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc %0d: got %b want 00000000", c, {grant, grant_valid, grant_id, expire});
      end
    end
    res_n = 1'b1;
    step();
    n_cmp++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_pick: got grant=%b id=%0d valid=%b want 0001/0/1", grant, grant_id, grant_valid);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] e;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = '0;
      e[g % N] = 1'b1;
      step();
      n_cmp++;
      if (grant !== e || grant_id !== IDW'(g % N)) begin
        n_err++;
        $display("FAIL rotation_a g=%0d: got %b/%0d want %b/%0d", g, grant, grant_id, e, g % N);
      end
      req = 4'b1111;
      step();
      n_cmp++;
      if (grant !== e || {grant, grant_valid, grant_id, expire} !== exp_vec()) begin
        n_err++;
        $display("FAIL rotation_b g=%0d: got %b want %b", g, grant, e);
      end
      req = 4'b1111 & ~e;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b1010;
    step();
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL b2b_first: got %b/%0d want 0010/1", grant, grant_id);
    end
    req = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (grant !== 4'b1000 || grant_valid !== 1'b1 || grant_id !== 2'd3) begin
        n_err++;
        $display("FAIL b2b_handoff cyc %0d: got %b/%b/%0d want 1000/1/3", c, grant, grant_valid, grant_id);
      end
    end
  endtask

  task automatic test_hold_limit();
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < MH; c++) begin
      step();
      n_cmp++;
      if (grant !== 4'b0001 || expire !== 1'b0) begin
        n_err++;
        $display("FAIL hold_own cyc %0d: got %b exp=%b want 0001 exp=0", c, grant, expire);
      end
    end
    if (HL) begin
      step();
      n_cmp++;
      if (grant !== 4'b0100 || expire !== 1'b1 || grant_id !== 2'd2) begin
        n_err++;
        $display("FAIL hold_revoke: got %b exp=%b id=%0d want 0100 exp=1 id=2", grant, expire, grant_id);
      end
      step();
      n_cmp++;
      if (grant !== 4'b0100 || expire !== 1'b0) begin
        n_err++;
        $display("FAIL hold_after: got %b exp=%b want 0100 exp=0", grant, expire);
      end
    end else begin
      for (int c = 0; c < 8; c++) begin
        step();
        n_cmp++;
        if (grant !== 4'b0001 || expire !== 1'b0) begin
          n_err++;
          $display("FAIL hold_nolimit cyc %0d: got %b exp=%b want 0001 exp=0", c, grant, expire);
        end
      end
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++;
      if (grant !== 4'b1000 || expire !== 1'b0) begin
        n_err++;
        $display("FAIL sole_hold cyc %0d: got %b exp=%b want 1000 exp=0", c, grant, expire);
      end
    end
    req = '0;
    step();
    n_cmp++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sole_release: got %b/%b want 0000/0", grant, grant_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    step();
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_err++;
      $display("FAIL async_pre: got %b want 0100", grant);
    end
    #2;
    res_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({grant, grant_valid, grant_id, expire} !== 8'b0) begin
      n_err++;
      $display("FAIL async_clear: got %b want 00000000", {grant, grant_valid, grant_id, expire});
    end
    #1;
    res_n = 1'b1;
    req = 4'b0110;
    step();
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL async_restart: got %b/%0d want 0010/1", grant, grant_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r = N'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      if ($urandom_range(0, 9) == 0) r = '0;
      req = r;
      if ($urandom_range(0, 299) == 0) begin
        res_n = 1'b0;
        m_reset();
      end else begin
        res_n = 1'b1;
      end
      step();
      n_cmp++;
      if ({grant, grant_valid, grant_id, expire} !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc %0d req=%b: got %b want %b", c, req, {grant, grant_valid, grant_id, expire}, exp_vec());
      end
      n_cmp++;
      if (!$onehot0(grant)) begin
        n_err++;
        $display("FAIL random_onehot cyc %0d: got %b want one-hot or zero", c, grant);
      end
    end
    res_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_back_to_back();
    test_hold_limit();
    test_sole_requester();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
